fft_input_loader: RTL and testbench

Streaming front end for the FFT accelerator: accepts complex samples on a valid/ready stream and writes them into the engine's sample memory in bit-reversed order. Once exactly N = 2^L samples are committed, it pulses the engine start. It sits directly upstream of the FFT engine's memory port and start input, replacing host-driven sample writes for real-time sources.

---
 rtl/fft_loader_pkg.sv | 23 ++
 rtl/fft_bitrev_addr.sv | 22 ++
 rtl/fft_input_loader.sv | 205 ++++++++++++++++++++
 tb/tb_fft_input_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_loader_pkg.sv
// Shared types and constants for the FFT input loader.
//   state_t      : loader FSM states
//   err_code_t   : sticky error code reported on err_code_o
//   FFT_MIN_LENGTH_LOG2 : smallest frame length accepted on arm
package fft_loader_pkg;

    localparam int unsigned FFT_MIN_LENGTH_LOG2 = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_START = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_BAD_LENGTH  = 2'd1,
        ERR_EARLY_LAST  = 2'd2,
        ERR_ENGINE_BUSY = 2'd3
    } err_code_t;

endpackage

// File: rtl/fft_bitrev_addr.sv
// Combinational bit-reversal of the low length_log2 bits of a sample index.
//   count       : sample index, assumed < 2^length_log2
//   length_log2 : active frame length L (L <= FFT_MAX_LENGTH_LOG2)
//   index       : count with its low L bits reversed, upper bits zero
module fft_bitrev_addr #(
    parameter int unsigned FFT_MAX_LENGTH_LOG2 = 12
) (
    input  logic [FFT_MAX_LENGTH_LOG2-1:0] count,
    input  logic [3:0]                     length_log2,
    output logic [FFT_MAX_LENGTH_LOG2-1:0] index
);
    localparam int unsigned SH_W = $clog2(FFT_MAX_LENGTH_LOG2 + 1);

    logic [FFT_MAX_LENGTH_LOG2-1:0] rev_full;
    logic [SH_W-1:0]                shift;

    // Reverse across the full width, then shift the result down so bit L-1 lands at bit 0.
    assign rev_full = {<<{count}};
    assign shift    = SH_W'(FFT_MAX_LENGTH_LOG2) - SH_W'(length_log2);
    assign index    = rev_full >> shift;

endmodule

// File: rtl/fft_input_loader.sv
// Streaming front end for the FFT accelerator. Accepts complex samples on a
// valid/ready stream, writes them into sample memory (bit-reversed order when
// FFT_LOADER_BITREV_EN is defined, natural order otherwise) and pulses the
// engine start once 2^L samples have been committed.
// Ports:
//   clk_i, reset_i (async, active-high)
//   cfg_length_log2_i, cfg_base_addr_i, arm_i, abort_i : frame control
//   s_valid_i, s_ready_o, s_data_i {imag, real}, s_last_i : sample stream
//   mem_addr_o, mem_data_o, mem_write_o, mem_ready_i      : memory write port
//   fft_busy_i, fft_start_o                               : engine handshake
//   busy_o, done_o, error_o, err_code_o, sample_count_o   : status
// s_ready_o is combinational; all other outputs are registered.
module fft_input_loader
    import fft_loader_pkg::*;
#(
    parameter int unsigned FFT_MAX_LENGTH_LOG2 = 12,
    parameter int unsigned DATA_WIDTH          = 16,
    parameter int unsigned MEM_ADDR_WIDTH      = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [3:0]                    cfg_length_log2_i,
    input  logic [MEM_ADDR_WIDTH-1:0]     cfg_base_addr_i,
    input  logic                          arm_i,
    input  logic                          abort_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [2*DATA_WIDTH-1:0]       s_data_i,
    input  logic                          s_last_i,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [2*DATA_WIDTH-1:0]       mem_data_o,
    output logic                          mem_write_o,
    input  logic                          mem_ready_i,
    input  logic                          fft_busy_i,
    output logic                          fft_start_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic [1:0]                    err_code_o,
    output logic [FFT_MAX_LENGTH_LOG2:0]  sample_count_o
);
    localparam int unsigned CNT_W = FFT_MAX_LENGTH_LOG2 + 1;
    localparam int unsigned SMP_W = 2 * DATA_WIDTH;
    localparam int unsigned IDX_W = FFT_MAX_LENGTH_LOG2;

    state_t                    state_q, state_n;
    err_code_t                 err_q, err_n;
    logic [3:0]                len_q, len_n;
    logic [MEM_ADDR_WIDTH-1:0] base_q, base_n;
    logic [CNT_W-1:0]          count_q, count_n;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [SMP_W-1:0]          data_q, data_n;
    logic                      write_q, write_n;
    logic                      start_q, start_n;
    logic                      done_q, done_n;
    logic                      error_q, error_n;
    logic                      busy_q, busy_n;

    logic [CNT_W-1:0]          last_idx;
    logic [IDX_W-1:0]          mem_idx;
    logic                      xfer;
    logic                      bad_len;

    // Index of the final sample of the frame (N-1).
    assign last_idx = (CNT_W'(1) << len_q) - CNT_W'(1);
    assign bad_len  = (cfg_length_log2_i < 4'(FFT_MIN_LENGTH_LOG2)) ||
                      (cfg_length_log2_i > 4'(FFT_MAX_LENGTH_LOG2));

`ifdef FFT_LOADER_BITREV_EN
    fft_bitrev_addr #(
        .FFT_MAX_LENGTH_LOG2(FFT_MAX_LENGTH_LOG2)
    ) u_bitrev (
        .count       (count_q[IDX_W-1:0]),
        .length_log2 (len_q),
        .index       (mem_idx)
    );
`else
    assign mem_idx = count_q[IDX_W-1:0];
`endif

    // State and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
            len_q   <= '0;
            base_q  <= '0;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            err_q   <= err_n;
            len_q   <= len_n;
            base_q  <= base_n;
            count_q <= count_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            write_q <= write_n;
            start_q <= start_n;
            done_q  <= done_n;
            error_q <= error_n;
            busy_q  <= busy_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_q;
        err_n   = err_q;
        len_n   = len_q;
        base_n  = base_q;
        count_n = count_q;
        addr_n  = addr_q;
        data_n  = data_q;
        write_n = write_q;
        error_n = 1'b0;

        // Single-entry write register: a new sample fits if it is empty or draining now.
        s_ready_o = (state_q == ST_LOAD) && (!write_q || mem_ready_i);
        xfer      = s_valid_i && s_ready_o;

        if (abort_i) begin
            state_n = ST_IDLE;
            write_n = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_i) begin
                        if (bad_len) begin
                            error_n = 1'b1;
                            err_n   = ERR_BAD_LENGTH;
                        end else if (fft_busy_i) begin
                            error_n = 1'b1;
                            err_n   = ERR_ENGINE_BUSY;
                        end else begin
                            len_n   = cfg_length_log2_i;
                            base_n  = cfg_base_addr_i;
                            count_n = '0;
                            err_n   = ERR_NONE;
                            state_n = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (write_q && mem_ready_i) begin
                        write_n = 1'b0;
                    end
                    if (xfer) begin
                        if (s_last_i && (count_q != last_idx)) begin
                            // Short frame: drop the sample and any pending write.
                            error_n = 1'b1;
                            err_n   = ERR_EARLY_LAST;
                            write_n = 1'b0;
                            state_n = ST_IDLE;
                        end else begin
                            addr_n  = base_q + MEM_ADDR_WIDTH'(mem_idx);
                            data_n  = s_data_i;
                            write_n = 1'b1;
                            count_n = count_q + CNT_W'(1);
                            if (count_q == last_idx) begin
                                state_n = ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (write_q && mem_ready_i) begin
                        write_n = 1'b0;
                    end
                    if (!write_q) begin
                        state_n = ST_START;
                    end
                end
                ST_START: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        // Pulses and busy are registered copies of the state being entered.
        start_n = (state_n == ST_START);
        done_n  = (state_n == ST_START);
        busy_n  = (state_n != ST_IDLE);
    end

    assign mem_addr_o     = addr_q;
    assign mem_data_o     = data_q;
    assign mem_write_o    = write_q;
    assign fft_start_o    = start_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign busy_o         = busy_q;
    assign err_code_o     = err_q;
    assign sample_count_o = count_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader: table of arm cases, randomized
// frames checked against a write-order model, plus hand sequences for early
// last, abort, async reset and address wrap.
module tb_fft_input_loader;

    localparam int unsigned MAXL = 12;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 16;

    logic              clk_i;
    logic              reset_i;
    logic [3:0]        cfg_length_log2_i;
    logic [AW-1:0]     cfg_base_addr_i;
    logic              arm_i;
    logic              abort_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [2*DW-1:0]   s_data_i;
    logic              s_last_i;
    logic [AW-1:0]     mem_addr_o;
    logic [2*DW-1:0]   mem_data_o;
    logic              mem_write_o;
    logic              mem_ready_i;
    logic              fft_busy_i;
    logic              fft_start_o;
    logic              busy_o;
    logic              done_o;
    logic              error_o;
    logic [1:0]        err_code_o;
    logic [MAXL:0]     sample_count_o;

    fft_input_loader #(
        .FFT_MAX_LENGTH_LOG2(MAXL),
        .DATA_WIDTH(DW),
        .MEM_ADDR_WIDTH(AW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cfg_length_log2_i(cfg_length_log2_i), .cfg_base_addr_i(cfg_base_addr_i),
        .arm_i(arm_i), .abort_i(abort_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_write_o(mem_write_o),
        .mem_ready_i(mem_ready_i),
        .fft_busy_i(fft_busy_i), .fft_start_o(fft_start_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .err_code_o(err_code_o), .sample_count_o(sample_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [AW-1:0]   obs_addr[$];
    logic [2*DW-1:0] obs_data[$];
    logic [2*DW-1:0] acc_data[$];
    int start_cnt, done_cnt, err_cnt, start_cyc, wr_cyc;
    bit was_stalled;
    logic [AW-1:0]   hold_addr;
    logic [2*DW-1:0] hold_data;

    typedef struct {
        logic [3:0] len;
        logic       eng_busy;
        int         code;
        int         err_pulse;
        int         busy;
        int         ready;
    } arm_vec_t;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
        end
    endtask

    // Reference write address: base plus the L-bit reversed (or natural) index, mod 2^16.
    function automatic int model_addr(input logic [AW-1:0] base, input int len, input int idx);
        int r;
        r = 0;
`ifdef FFT_LOADER_BITREV_EN
        for (int b = 0; b < len; b++) r = (r * 2) + ((idx >> b) & 1);
`else
        r = idx + 0 * len;
`endif
        return (int'(base) + r) % 65536;
    endfunction

    function automatic logic ready_val(input int rmode);
        case (rmode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return 1'($urandom_range(1));
        endcase
    endfunction

    // Observe one cycle just before the clock edge, then advance to the next falling edge.
    task automatic tick();
        #1;
        if (was_stalled) begin
            chk("stall_write_held", int'(mem_write_o), 1);
            chk("stall_addr_stable", int'(mem_addr_o), int'(hold_addr));
            chk("stall_data_stable", int'(mem_data_o), int'(hold_data));
        end
        if (mem_write_o && mem_ready_i) begin
            obs_addr.push_back(mem_addr_o);
            obs_data.push_back(mem_data_o);
            wr_cyc = cyc;
        end
        if (s_valid_i && s_ready_o) acc_data.push_back(s_data_i);
        if (fft_start_o) begin start_cnt++; start_cyc = cyc; end
        if (done_o) done_cnt++;
        if (error_o) err_cnt++;
        was_stalled = mem_write_o && !mem_ready_i && !abort_i && !reset_i;
        hold_addr = mem_addr_o;
        hold_data = mem_data_o;
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic clear_mon();
        obs_addr.delete();
        obs_data.delete();
        acc_data.delete();
        start_cnt = 0; done_cnt = 0; err_cnt = 0; start_cyc = 0; wr_cyc = 0;
        was_stalled = 1'b0;
    endtask

    task automatic do_arm(input int len, input logic [AW-1:0] base);
        cfg_length_log2_i = 4'(len);
        cfg_base_addr_i   = base;
        s_valid_i = 1'b0; s_last_i = 1'b0; mem_ready_i = 1'b1;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("arm_busy", int'(busy_o), 1);
    endtask

    task automatic feed(input int target, input int last_at, input int vpct, input int rmode, input int budget);
        int spent;
        spent = 0;
        while (acc_data.size() < target && spent < budget) begin
            s_valid_i   = int'($urandom_range(99)) < vpct;
            s_data_i    = $urandom;
            s_last_i    = s_valid_i && (acc_data.size() == last_at);
            mem_ready_i = ready_val(rmode);
            tick();
            spent++;
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        chk("feed_accepted", acc_data.size(), target);
    endtask

    task automatic wait_start(input int rmode, input int budget);
        int spent;
        spent = 0;
        while (start_cnt == 0 && spent < budget) begin
            mem_ready_i = ready_val(rmode);
            tick();
            spent++;
        end
        chk("start_seen", start_cnt, 1);
    endtask

    task automatic check_frame(input logic [AW-1:0] base, input int len, input int n, input string tag);
        chk({tag, "_write_count"}, obs_addr.size(), n);
        for (int k = 0; k < n && k < obs_addr.size() && k < acc_data.size(); k++) begin
            chk($sformatf("%s_addr[%0d]", tag, k), int'(obs_addr[k]), model_addr(base, len, k));
            chk($sformatf("%s_data[%0d]", tag, k), int'(obs_data[k]), int'(acc_data[k]));
        end
    endtask

    task automatic run_full(input int len, input logic [AW-1:0] base, input int vpct,
                            input int rmode, input bit flag_last, input string tag);
        int n;
        n = 1 << len;
        clear_mon();
        do_arm(len, base);
        feed(n, flag_last ? n - 1 : -1, vpct, rmode, 20000);
        wait_start(rmode, 200);
        mem_ready_i = 1'b1;
        tick();
        chk({tag, "_start_pulses"}, start_cnt, 1);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_error_pulses"}, err_cnt, 0);
        chk({tag, "_start_latency"}, start_cyc - wr_cyc, 2);
        chk({tag, "_busy_after"}, int'(busy_o), 0);
        chk({tag, "_err_code"}, int'(err_code_o), 0);
        chk({tag, "_sample_count"}, int'(sample_count_o), n);
        check_frame(base, len, n, tag);
    endtask

    initial begin
        arm_vec_t tbl[6];
        tbl[0] = '{4'd7,  1'b0, 1, 1, 0, 0};
        tbl[1] = '{4'd13, 1'b0, 1, 1, 0, 0};
        tbl[2] = '{4'd9,  1'b1, 3, 1, 0, 0};
        tbl[3] = '{4'd0,  1'b0, 1, 1, 0, 0};
        tbl[4] = '{4'd15, 1'b1, 1, 1, 0, 0};
        tbl[5] = '{4'd8,  1'b0, 0, 0, 1, 1};

        reset_i = 1'b1;
        cfg_length_log2_i = '0; cfg_base_addr_i = '0;
        arm_i = 1'b0; abort_i = 1'b0;
        s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0;
        mem_ready_i = 1'b0; fft_busy_i = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk_i);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_write", int'(mem_write_o), 0);
        chk("rst_err_code", int'(err_code_o), 0);
        chk("rst_count", int'(sample_count_o), 0);
        reset_i = 1'b0;
        tick();

        // Arm decisions from the table.
        for (int i = 0; i < 6; i++) begin
            cfg_length_log2_i = tbl[i].len;
            cfg_base_addr_i   = 16'h2000;
            fft_busy_i        = tbl[i].eng_busy;
            mem_ready_i       = 1'b1;
            arm_i             = 1'b1;
            tick();
            arm_i      = 1'b0;
            fft_busy_i = 1'b0;
            #1;
            chk($sformatf("arm%0d_error", i), int'(error_o), tbl[i].err_pulse);
            chk($sformatf("arm%0d_code", i), int'(err_code_o), tbl[i].code);
            chk($sformatf("arm%0d_busy", i), int'(busy_o), tbl[i].busy);
            chk($sformatf("arm%0d_ready", i), int'(s_ready_o), tbl[i].ready);
            abort_i = tbl[i].busy != 0;
            tick();
            abort_i = 1'b0;
            chk($sformatf("arm%0d_error_gone", i), int'(error_o), 0);
            chk($sformatf("arm%0d_idle", i), int'(busy_o), 0);
        end

        // Back-to-back L=8 frame with last on the final sample.
        run_full(8, 16'h1000, 100, 0, 1'b1, "l8");
        if (obs_addr.size() == 256) begin
`ifdef FFT_LOADER_BITREV_EN
            chk("l8_addr1", int'(obs_addr[1]), 'h1080);
            chk("l8_addr3", int'(obs_addr[3]), 'h10C0);
`else
            chk("l8_addr1", int'(obs_addr[1]), 'h1001);
            chk("l8_addr3", int'(obs_addr[3]), 'h1003);
`endif
            chk("l8_addr255", int'(obs_addr[255]), 'h10FF);
        end

        // L=12 with memory accepting one cycle in three.
        run_full(12, 16'h0000, 90, 1, 1'b0, "l12");

        // Random frames.
        for (int f = 0; f < 2; f++) begin
            run_full(8 + int'($urandom_range(2)), 16'($urandom), 60, 2, 1'($urandom_range(1)), "rnd");
        end

        // Early last on sample 100 of a 512-sample frame.
        clear_mon();
        do_arm(9, 16'h3000);
        feed(101, 100, 80, 2, 3000);
        mem_ready_i = 1'b1;
        repeat (3) tick();
        chk("early_error_pulses", err_cnt, 1);
        chk("early_err_code", int'(err_code_o), 2);
        chk("early_starts", start_cnt, 0);
        chk("early_busy", int'(busy_o), 0);
        check_frame(16'h3000, 9, 100, "early");

        // Arm while loading is ignored; abort with a write pending.
        clear_mon();
        do_arm(8, 16'h4000);
        feed(20, -1, 100, 0, 500);
        cfg_length_log2_i = 4'd7;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        feed(50, -1, 100, 0, 500);
        chk("abort_pending_before", int'(mem_write_o), 1);
        mem_ready_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_write_dropped", int'(mem_write_o), 0);
        chk("abort_busy", int'(busy_o), 0);
        mem_ready_i = 1'b1;
        repeat (3) tick();
        chk("abort_starts", start_cnt, 0);
        chk("abort_errors", err_cnt, 0);
        chk("abort_err_code", int'(err_code_o), 0);
        chk("abort_writes", obs_addr.size(), 49);
        run_full(8, 16'h5000, 100, 0, 1'b0, "rearm");

        // Asynchronous reset mid-frame.
        clear_mon();
        do_arm(8, 16'h6000);
        feed(30, -1, 100, 0, 500);
        s_valid_i = 1'b0;
        mem_ready_i = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        chk("areset_ready", int'(s_ready_o), 0);
        chk("areset_write", int'(mem_write_o), 0);
        chk("areset_start", int'(fft_start_o), 0);
        chk("areset_done", int'(done_o), 0);
        chk("areset_error", int'(error_o), 0);
        chk("areset_busy", int'(busy_o), 0);
        chk("areset_addr", int'(mem_addr_o), 0);
        chk("areset_data", int'(mem_data_o), 0);
        chk("areset_count", int'(sample_count_o), 0);
        chk("areset_err_code", int'(err_code_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        was_stalled = 1'b0;
        tick();

        // Address wrap past 0xFFFF.
        run_full(8, 16'hFF80, 70, 2, 1'b0, "wrap");
        if (obs_addr.size() == 256) begin
`ifdef FFT_LOADER_BITREV_EN
            chk("wrap_addr1", int'(obs_addr[1]), 'h0000);
`else
            chk("wrap_addr1", int'(obs_addr[1]), 'hFF81);
`endif
            chk("wrap_addr255", int'(obs_addr[255]), 'h007F);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
